// File: rtl/jt49_bus_arb_if.sv
// Single requester port of the JT49 register-access arbiter.
// The requester drives the request fields; the arbiter returns ready and read responses.
interface jt49_bus_arb_if;
    logic       valid;
    logic       ready;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/jt49_bus_arb.sv
// Round-robin two-port arbiter that serialises JT49 register reads/writes into
// one-cycle PSG strobes with a guaranteed idle gap, answering reg 13 reads from a shadow.
module jt49_bus_arb #(
    parameter int GAP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    jt49_bus_arb_if.slave   r0,
    jt49_bus_arb_if.slave   r1,
    output logic            psg_cs_n,
    output logic            psg_wr_n,
    output logic [3:0]      psg_addr,
    output logic [7:0]      psg_din,
    input  logic [7:0]      psg_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic       lastGrant_q, lastGrant_d;
    logic       owner_q, owner_d;
    logic [3:0] gapCnt_q, gapCnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic       csN_q, csN_d;
    logic       wrN_q, wrN_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;

    logic       grant0, grant1;
    logic       accept;
    logic       selWe;
    logic [3:0] selAddr;
    logic [7:0] selWdata;
    logic       shadowRead;

    // On a tie the requester that was not served last wins.
    assign grant1 = r1.valid & (~r0.valid | ~lastGrant_q);
    assign grant0 = r0.valid & ~grant1;

    assign accept     = (state_q == S_IDLE) & (grant0 | grant1);
    assign selWe      = grant1 ? r1.we    : r0.we;
    assign selAddr    = grant1 ? r1.addr  : r0.addr;
    assign selWdata   = grant1 ? r1.wdata : r0.wdata;
    assign shadowRead = ~selWe & (selAddr == 4'd13);

    assign r0.ready  = (state_q == S_IDLE) & grant0;
    assign r1.ready  = (state_q == S_IDLE) & grant1;
    assign r0.rdata  = rdata0_q;
    assign r1.rdata  = rdata1_q;
    assign r0.rvalid = rvalid0_q;
    assign r1.rvalid = rvalid1_q;

    assign psg_cs_n = csN_q;
    assign psg_wr_n = wrN_q;
    assign psg_addr = addr_q;
    assign psg_din  = din_q;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        gapCnt_d    = gapCnt_q;
        shadow_d    = shadow_q;
        csN_d       = csN_q;
        wrN_d       = wrN_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lastGrant_d = grant1;
                    if (selWe && (selAddr == 4'd13)) begin
                        shadow_d = selWdata;
                    end
                    // Envelope-shape reads never touch the PSG, so the envelope keeps running.
                    if (shadowRead) begin
                        if (grant1) begin
                            rdata1_d  = shadow_q;
                            rvalid1_d = 1'b1;
                        end else begin
                            rdata0_d  = shadow_q;
                            rvalid0_d = 1'b1;
                        end
                    end else begin
                        owner_d = grant1;
                        addr_d  = selAddr;
                        din_d   = selWdata;
                        wrN_d   = ~selWe;
                        csN_d   = 1'b0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                csN_d = 1'b1;
                wrN_d = 1'b1;
                if (!wrN_q) begin
                    gapCnt_d = 4'(GAP);
                    state_d  = S_GAP;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (owner_q) begin
                    rdata1_d  = psg_dout;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = psg_dout;
                    rvalid0_d = 1'b1;
                end
                gapCnt_d = 4'(GAP);
                state_d  = S_GAP;
            end
            S_GAP: begin
                gapCnt_d = gapCnt_q - 4'd1;
                if (gapCnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            gapCnt_q    <= 4'd0;
            shadow_q    <= 8'd0;
            csN_q       <= 1'b1;
            wrN_q       <= 1'b1;
            addr_q      <= 4'd0;
            din_q       <= 8'd0;
            rdata0_q    <= 8'd0;
            rdata1_q    <= 8'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            gapCnt_q    <= gapCnt_d;
            shadow_q    <= shadow_d;
            csN_q       <= csN_d;
            wrN_q       <= wrN_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Directed bench for jt49_bus_arb: three instances (GAP = 1, 2, 15) share one
// requester stimulus; each scenario resets all of them and checks the relevant one.
module tb_jt49_bus_arb;

    logic       clk;
    logic       rst_n;
    logic       r0Valid, r0We, r1Valid, r1We;
    logic [3:0] r0Addr, r1Addr;
    logic [7:0] r0Wdata, r1Wdata;

    int checkCount = 0;
    int failCount  = 0;

    jt49_bus_arb_if if1_0 ();
    jt49_bus_arb_if if1_1 ();
    jt49_bus_arb_if if2_0 ();
    jt49_bus_arb_if if2_1 ();
    jt49_bus_arb_if if15_0 ();
    jt49_bus_arb_if if15_1 ();

    assign if1_0.valid  = r0Valid;  assign if1_0.we  = r0We;  assign if1_0.addr  = r0Addr;  assign if1_0.wdata  = r0Wdata;
    assign if1_1.valid  = r1Valid;  assign if1_1.we  = r1We;  assign if1_1.addr  = r1Addr;  assign if1_1.wdata  = r1Wdata;
    assign if2_0.valid  = r0Valid;  assign if2_0.we  = r0We;  assign if2_0.addr  = r0Addr;  assign if2_0.wdata  = r0Wdata;
    assign if2_1.valid  = r1Valid;  assign if2_1.we  = r1We;  assign if2_1.addr  = r1Addr;  assign if2_1.wdata  = r1Wdata;
    assign if15_0.valid = r0Valid;  assign if15_0.we = r0We;  assign if15_0.addr = r0Addr;  assign if15_0.wdata = r0Wdata;
    assign if15_1.valid = r1Valid;  assign if15_1.we = r1We;  assign if15_1.addr = r1Addr;  assign if15_1.wdata = r1Wdata;

    logic       cs1, wr1, cs2, wr2, cs15, wr15;
    logic [3:0] addr1, addr2, addr15;
    logic [7:0] din1, din2, din15;
    logic [7:0] dout1, dout2, dout15;

    jt49_bus_arb #(.GAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .r0(if1_0), .r1(if1_1),
        .psg_cs_n(cs1), .psg_wr_n(wr1), .psg_addr(addr1), .psg_din(din1), .psg_dout(dout1)
    );

    jt49_bus_arb #(.GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .r0(if2_0), .r1(if2_1),
        .psg_cs_n(cs2), .psg_wr_n(wr2), .psg_addr(addr2), .psg_din(din2), .psg_dout(dout2)
    );

    jt49_bus_arb #(.GAP(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .r0(if15_0), .r1(if15_1),
        .psg_cs_n(cs15), .psg_wr_n(wr15), .psg_addr(addr15), .psg_din(din15), .psg_dout(dout15)
    );

    // PSG read model: register 8 reads 0xA5, others read their own index, one cycle after the address.
    always_ff @(posedge clk) begin
        dout1  <= (addr1  == 4'd8) ? 8'hA5 : {4'h0, addr1};
        dout2  <= (addr2  == 4'd8) ? 8'hA5 : {4'h0, addr2};
        dout15 <= (addr15 == 4'd8) ? 8'hA5 : {4'h0, addr15};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                                 input logic v1, input logic we1, input logic [3:0] a1, input logic [7:0] d1);
        r0Valid = v0; r0We = we0; r0Addr = a0; r0Wdata = d0;
        r1Valid = v1; r1We = we1; r1Addr = a1; r1Wdata = d1;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        int acc;
        int nStrobe;
        int strobeAt[4];

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        nextCycle();
        nextCycle();
        settle();
        $display("[TB] reset values");
        checkOutput("rst_cs_n", cs1, 1'b1);
        checkOutput("rst_wr_n", wr1, 1'b1);
        checkOutput("rst_addr", addr1, 4'd0);
        checkOutput("rst_din", din1, 8'd0);
        checkOutput("rst_rdata0", if1_0.rdata, 8'd0);
        checkOutput("rst_rvalid0", if1_0.rvalid, 1'b0);
        checkOutput("rst_rdata1", if1_1.rdata, 8'd0);
        checkOutput("rst_rvalid1", if1_1.rvalid, 1'b0);

        $display("[TB] single write, GAP=1");
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 1'b1, 4'd7, 8'h38, 1'b0, 1'b0, 4'd0, 8'd0);
        settle();
        checkOutput("wr_ready0_t", if1_0.ready, 1'b1);
        checkOutput("wr_ready1_t", if1_1.ready, 1'b0);
        checkOutput("wr_cs_t", cs1, 1'b1);
        nextCycle();
        r0Valid = 1'b0;
        settle();
        checkOutput("wr_cs_t1", cs1, 1'b0);
        checkOutput("wr_wr_t1", wr1, 1'b0);
        checkOutput("wr_addr_t1", addr1, 4'd7);
        checkOutput("wr_din_t1", din1, 8'h38);
        checkOutput("wr_ready0_t1", if1_0.ready, 1'b0);
        nextCycle();
        settle();
        checkOutput("wr_cs_t2", cs1, 1'b1);
        checkOutput("wr_wr_t2", wr1, 1'b1);
        checkOutput("wr_din_hold", din1, 8'h38);

        $display("[TB] contention, GAP=1");
        applyReset();
        applyStimulus(1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22);
        for (int k = 0; k < 9; k++) begin
            settle();
            checkOutput($sformatf("cont_ready0_%0d", k), if1_0.ready, (k == 0 || k == 6));
            checkOutput($sformatf("cont_ready1_%0d", k), if1_1.ready, (k == 3));
            checkOutput($sformatf("cont_cs_%0d", k), cs1, !(k == 1 || k == 4 || k == 7));
            if (k == 1 || k == 4 || k == 7) begin
                checkOutput($sformatf("cont_addr_%0d", k), addr1, (k == 4) ? 4'd2 : 4'd1);
            end
            nextCycle();
        end

        $display("[TB] envelope retrigger, GAP=2");
        applyReset();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd13, 8'h0E);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) r1Valid = 1'b0;
            settle();
            checkOutput($sformatf("env_ready1_%0d", k), if2_1.ready, (k == 0 || k == 4));
            checkOutput($sformatf("env_cs_%0d", k), cs2, !(k == 1 || k == 5));
            if (k == 1 || k == 5) begin
                checkOutput($sformatf("env_din_%0d", k), din2, 8'h0E);
                checkOutput($sformatf("env_addr_%0d", k), addr2, 4'd13);
            end
            nextCycle();
        end
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'd13, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        settle();
        checkOutput("shd_ready0", if2_0.ready, 1'b1);
        nextCycle();
        r0Valid = 1'b0;
        settle();
        checkOutput("shd_rvalid0", if2_0.rvalid, 1'b1);
        checkOutput("shd_rdata0", if2_0.rdata, 8'h0E);
        checkOutput("shd_cs_t1", cs2, 1'b1);
        nextCycle();
        settle();
        checkOutput("shd_rvalid0_t2", if2_0.rvalid, 1'b0);
        checkOutput("shd_cs_t2", cs2, 1'b1);
        checkOutput("shd_rdata_hold", if2_0.rdata, 8'h0E);

        $display("[TB] PSG read, GAP=1");
        applyReset();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd8, 8'd0);
        settle();
        checkOutput("rd_ready1", if1_1.ready, 1'b1);
        nextCycle();
        r1Valid = 1'b0;
        settle();
        checkOutput("rd_cs_t1", cs1, 1'b0);
        checkOutput("rd_wr_t1", wr1, 1'b1);
        checkOutput("rd_addr_t1", addr1, 4'd8);
        nextCycle();
        settle();
        checkOutput("rd_rvalid1_t2", if1_1.rvalid, 1'b0);
        nextCycle();
        settle();
        checkOutput("rd_rvalid1_t3", if1_1.rvalid, 1'b1);
        checkOutput("rd_rdata1_t3", if1_1.rdata, 8'hA5);
        checkOutput("rd_rvalid0_t3", if1_0.rvalid, 1'b0);
        nextCycle();
        settle();
        checkOutput("rd_rvalid1_t4", if1_1.rvalid, 1'b0);
        checkOutput("rd_rdata1_hold", if1_1.rdata, 8'hA5);

        $display("[TB] reset during access");
        applyReset();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd8, 8'd0);
        nextCycle();
        r1Valid = 1'b0;
        rst_n = 1'b0;
        settle();
        checkOutput("mid_cs_access", cs1, 1'b0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd3, 8'h33, 1'b1, 1'b1, 4'd4, 8'h44);
        settle();
        checkOutput("mid_cs_after", cs1, 1'b1);
        checkOutput("mid_rvalid1_t2", if1_1.rvalid, 1'b0);
        checkOutput("mid_tie_ready0", if1_0.ready, 1'b1);
        checkOutput("mid_tie_ready1", if1_1.ready, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        settle();
        checkOutput("mid_rvalid1_t3", if1_1.rvalid, 1'b0);
        checkOutput("mid_cs_r0", cs1, 1'b0);
        checkOutput("mid_addr_r0", addr1, 4'd3);

        $display("[TB] GAP=15 throughput");
        applyReset();
        acc = 0;
        nStrobe = 0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus(acc < 4, 1'b1, 4'd1, 8'h10 + 8'(acc), 1'b0, 1'b0, 4'd0, 8'd0);
            settle();
            if (if15_0.ready) acc++;
            if (!cs15) begin
                if (nStrobe < 4) begin
                    strobeAt[nStrobe] = k;
                    checkOutput($sformatf("thr_din_%0d", nStrobe), din15, 8'h10 + 8'(nStrobe));
                end
                nStrobe++;
            end
            nextCycle();
        end
        r0Valid = 1'b0;
        checkOutput("thr_strobes", nStrobe, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nStrobe) begin
                checkOutput($sformatf("thr_cycle_%0d", i), strobeAt[i], 1 + 17 * i);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/jt49_bus_arb.md
# jt49_bus_arb

Two-port register-access arbiter and sequencer for the JT49 PSG register port. It sits between two independent requesters (typically the CPU bus bridge and a music/stream player) and the PSG's cs_n/wr_n/addr/din/dout interface. It serialises their reads and writes with round-robin fairness and issues one-cycle PSG strobes separated by a guaranteed idle gap, so back-to-back writes to the envelope-shape register each retrigger the envelope. Reads of register 13 are answered from a shadow copy, so a read never restarts the envelope.

## Interface
Parameters:
- GAP, 1: idle cycles (psg_cs_n high) after every PSG strobe; legal range 1..15.

Ports (N = 0, 1):
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- rN_valid  in  1  requester N has an access pending.
- rN_ready  out  1  access accepted this cycle (valid & ready = handshake).
- rN_we  in  1  1 = write, 0 = read.
- rN_addr  in  4  PSG register index.
- rN_wdata  in  8  write data.
- rN_rdata  out  8  read data; valid while rN_rvalid is high.
- rN_rvalid  out  1  one-cycle read-response pulse.
- psg_cs_n  out  1  PSG chip select, registered.
- psg_wr_n  out  1  PSG write strobe, registered.
- psg_addr  out  4  PSG address, registered.
- psg_din  out  8  PSG write data, registered.
- psg_dout  in  8  PSG read data; valid one cycle after the cs_n-low cycle.

## Operation
- States: IDLE, ACCESS, CAPTURE, GAP.
- IDLE: if any rN_valid is high, grant one requester.
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - rN_ready = (state == IDLE) & grantN. It is combinational from valid, and at most one ready is high per cycle.
- On accept of a PSG access:
  - Register psg_addr <= rN_addr, psg_din <= rN_wdata, psg_wr_n <= ~rN_we, psg_cs_n <= 0.
  - Record the owner N, update the pointer, go to ACCESS.
- Shadow read (rN_we = 0 and rN_addr = 13):
  - No PSG strobe is issued; the pointer is updated.
  - Register rN_rdata <= shadow13 and rN_rvalid <= 1. The state stays IDLE, so a new grant is possible in the very next cycle.
- Any accepted write to address 13 also updates shadow13 <= wdata in the accept cycle.
- ACCESS (one cycle, cs_n low):
  - psg_cs_n <= 1 and psg_wr_n <= 1.
  - Write: load the gap counter with GAP, go to GAP.
  - Read: go to CAPTURE.
- CAPTURE (one cycle): register owner rdata <= psg_dout and owner rvalid <= 1. Load the gap counter, go to GAP.
- GAP: decrement the counter each cycle. When it reaches 0, go to IDLE; the final GAP cycle is the last one before IDLE.
- rN_rvalid is high for exactly one cycle per read. rN_rdata holds its value until the next read response to that requester.
- psg_addr and psg_din hold their last values outside the strobe.

## Timing
- Reset values:
  - psg_cs_n = 1, psg_wr_n = 1, psg_addr = 0, psg_din = 0.
  - rN_rdata = 0, rN_rvalid = 0, shadow13 = 0, state = IDLE, pointer = 1.
- Reset takes effect at the first posedge that samples rst_n low. An in-flight access is abandoned: cs_n returns high at that edge and no rvalid is produced for it.
- Write, accepted in cycle t:
  - cs_n is low in cycle t+1.
  - GAP occupies cycles t+2 .. t+1+GAP.
  - IDLE is reached at t+2+GAP, so sustained write throughput is one write per GAP+2 cycles.
- PSG read, accepted in cycle t:
  - cs_n is low in t+1; psg_dout is valid in t+2.
  - rvalid is high in t+3.
  - IDLE is reached at t+3+GAP.
- Shadow read accepted in cycle t: rvalid is high in t+1.
- A requester may change its valid/addr/data freely in the cycle after its handshake.
- Requests arriving in non-IDLE states wait with ready low; no request is dropped.

## Test plan
- Single write, GAP=1: r0 writes addr 7 = 0x38 at cycle t -> psg_cs_n=0, psg_wr_n=0, addr=7, din=0x38 only in t+1; cs_n high at t+2; r0_ready high only at t.
- Contention: r0 and r1 both hold valid writes continuously -> grants alternate r0, r1, r0, r1; PSG strobes are 3 cycles apart with GAP=1.
- Envelope retrigger: r1 writes addr 13 = 0x0E twice back to back, GAP=2 -> two distinct cs_n-low pulses separated by 3 cycles of cs_n high; a following r0 read of 13 returns 0x0E at t+1 with no PSG strobe.
- PSG read: PSG model returns 0xA5 on register 8; r1 reads addr 8 -> cs_n low with wr_n=1 at t+1, r1_rvalid=1 and r1_rdata=0xA5 at t+3; r0_rvalid stays 0.
- Reset mid-access: assert rst_n low during the ACCESS cycle of a read -> next cycle cs_n=1, no rvalid; a subsequent r0/r1 tie grants r0 first.
- GAP=15 throughput: 4 queued writes on r0 -> strobes exactly 17 cycles apart.
